// File: rtl/cond_if.sv
// cond_if: decoder/ALU-to-condition-logic bundle carrying control inputs and gated outputs.
interface cond_if;
    logic       Valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic [1:0] FlagW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
    modport master (
        output Valid, Cond, ALUFlags, PCS, RegW, MemW, NoWrite, FlagW,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
    modport slave (
        input  Valid, Cond, ALUFlags, PCS, RegW, MemW, NoWrite, FlagW,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/cond_logic.sv
// cond_logic: ARM-style condition check gating PC/register/memory writes and owning the NZCV register.
module cond_logic (
    input  logic   CLK,
    input  logic   Reset,
    cond_if.slave  bus
);
    logic [3:0]  flags_q;
    logic [3:0]  flags_d;
    logic        n, z, c, v, cond_ex;
    logic [15:0] pass;
    assign {n, z, c, v} = flags_q;
    // Indexed by Cond; evaluated only on registered flags so ALUFlags never reaches the gates.
    assign pass = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                   ~v, v, ~n, n, ~c, c, ~z, z};
    assign cond_ex      = bus.Valid & pass[bus.Cond];
    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex;
    assign bus.RegWrite = bus.RegW & ~bus.NoWrite & cond_ex;
    assign bus.MemWrite = bus.MemW & cond_ex;
    assign bus.Flags    = flags_q;
    always_comb begin
        flags_d[3:2] = (cond_ex & bus.FlagW[1]) ? bus.ALUFlags[3:2] : flags_q[3:2];
        flags_d[1:0] = (cond_ex & bus.FlagW[0]) ? bus.ALUFlags[1:0] : flags_q[1:0];
    end
    always_ff @(posedge CLK)
        flags_q <= Reset ? 4'b0000 : flags_d;
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: table-driven directed vectors plus a full Cond x Flags sweep for cond_logic.
module tb_cond_logic;
    logic CLK = 1'b0;
    logic Reset;
    int   n_vec = 0;
    int   n_err = 0;
    cond_if bus ();
    cond_logic dut (.CLK(CLK), .Reset(Reset), .bus(bus));
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowrite;
        logic       e_condex;
        logic       e_pcsrc;
        logic       e_regwrite;
        logic       e_memwrite;
        logic [3:0] e_flags;
    } vec_t;

    vec_t tv [18];

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        Reset        = t.rst;
        bus.Valid    = t.valid;
        bus.Cond     = t.cond;
        bus.ALUFlags = t.alu;
        bus.FlagW    = t.flagw;
        bus.PCS      = t.pcs;
        bus.RegW     = t.regw;
        bus.MemW     = t.memw;
        bus.NoWrite  = t.nowrite;
    endtask

    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (cond)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        //        rst  vld  cond  alu    fw     pcs  rgw  mw   nw    cex  pc   rw   mw   flags
        tv[0]  = '{1'b1,1'b0,4'hE,4'hF,2'b11,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'b0000};
        tv[1]  = '{1'b0,1'b1,4'hE,4'h0,2'b00,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,4'b0000};
        tv[2]  = '{1'b0,1'b1,4'h0,4'hF,2'b11,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'b0000};
        tv[3]  = '{1'b0,1'b1,4'hE,4'hF,2'b10,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,4'b1100};
        tv[4]  = '{1'b0,1'b1,4'hE,4'h0,2'b01,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,4'b1100};
        tv[5]  = '{1'b0,1'b1,4'hE,4'h6,2'b11,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,4'b0110};
        tv[6]  = '{1'b0,1'b1,4'h0,4'h0,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,4'b0110};
        tv[7]  = '{1'b0,1'b1,4'h1,4'h0,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,4'b0110};
        tv[8]  = '{1'b0,1'b1,4'hE,4'h9,2'b11,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,4'b1001};
        tv[9]  = '{1'b0,1'b0,4'hE,4'h6,2'b11,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,4'b1001};
        tv[10] = '{1'b0,1'b1,4'hA,4'h0,2'b11,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,4'b0000};
        tv[11] = '{1'b0,1'b1,4'hB,4'hF,2'b11,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'b0000};
        tv[12] = '{1'b0,1'b1,4'hC,4'h3,2'b01,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,4'b0011};
        tv[13] = '{1'b0,1'b1,4'h8,4'h4,2'b10,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,4'b0111};
        tv[14] = '{1'b1,1'b1,4'h9,4'hA,2'b11,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,4'b0000};
        tv[15] = '{1'b0,1'b1,4'h0,4'h0,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,4'b0000};
        tv[16] = '{1'b0,1'b1,4'h1,4'h0,2'b00,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,4'b0000};
        tv[17] = '{1'b0,1'b1,4'hF,4'hF,2'b11,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,4'b0000};

        drive(tv[0]);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_flags", 0, bus.Flags, 4'b0000);

        for (int i = 0; i < 18; i++) begin
            drive(tv[i]);
            #2;
            chk("CondEx",   i, {3'b0, bus.CondEx},   {3'b0, tv[i].e_condex});
            chk("PCSrc",    i, {3'b0, bus.PCSrc},    {3'b0, tv[i].e_pcsrc});
            chk("RegWrite", i, {3'b0, bus.RegWrite}, {3'b0, tv[i].e_regwrite});
            chk("MemWrite", i, {3'b0, bus.MemWrite}, {3'b0, tv[i].e_memwrite});
            @(posedge CLK);
            #1;
            chk("Flags", i, bus.Flags, tv[i].e_flags);
        end

        // Load each flag pattern with an AL flag-setter, then sweep every Cond while ALUFlags
        // carries the complement to expose any forwarding from ALUFlags.
        for (int f = 0; f < 16; f++) begin
            Reset = 1'b0; bus.Valid = 1'b1; bus.Cond = 4'hE; bus.FlagW = 2'b11;
            bus.ALUFlags = 4'(f); bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
            @(posedge CLK);
            #1;
            chk("sweep_flags", f, bus.Flags, 4'(f));
            bus.FlagW = 2'b00;
            bus.ALUFlags = ~4'(f);
            for (int c = 0; c < 16; c++) begin
                bus.Cond = 4'(c);
                #1;
                chk("sweep_condex", f * 16 + c, {3'b0, bus.CondEx}, {3'b0, ref_cond(4'(c), 4'(f))});
            end
        end

        // Reset coinciding with a flag write, then first post-reset instruction sees 0000.
        bus.Cond = 4'hE; bus.FlagW = 2'b11; bus.ALUFlags = 4'hF;
        @(posedge CLK);
        #1;
        chk("pre_reset_flags", 0, bus.Flags, 4'hF);
        Reset = 1'b1; bus.ALUFlags = 4'h5;
        @(posedge CLK);
        #1;
        chk("reset_vs_write", 0, bus.Flags, 4'b0000);
        Reset = 1'b0; bus.FlagW = 2'b00; bus.Cond = 4'h0;
        #1;
        chk("post_reset_eq", 0, {3'b0, bus.CondEx}, 4'b0000);
        bus.Cond = 4'h1;
        #1;
        chk("post_reset_ne", 0, {3'b0, bus.CondEx}, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
